// File: rtl/store_narrow_rmw_pkg.sv
// Shared encodings and helpers for the store-side narrowing path.
// The load-side extender imports the same size encodings.
package store_narrow_rmw_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_ERR
    } state_t;

    // Size 11 is illegal; halves need addr[0]=0, words need addr[1:0]=0.
    function automatic logic size_illegal(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian lane replacement: byte lane = lo, half lane = lo[1].
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input logic [1:0]  lo,
                                               input logic [1:0]  size);
        logic [31:0] merged;
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{lo, 3'b000} +: 8]     = data[7:0];
            SZ_HALF: merged[{lo[1], 4'b0000} +: 16] = data[15:0];
            default: merged = data;
        endcase
        return merged;
    endfunction

    // Discarded upper bits must be all zero or a copy of the kept sign bit.
    function automatic logic trunc_check(input logic signed [31:0] data,
                                         input logic [1:0]         size);
        logic ovf;
        case (size)
            SZ_BYTE: ovf = (data[31:8] != 24'd0) && (data[31:8] != {24{data[7]}});
            SZ_HALF: ovf = (data[31:16] != 16'd0) && (data[31:16] != {16{data[15]}});
            default: ovf = 1'b0;
        endcase
        return ovf;
    endfunction

endpackage

// File: rtl/store_narrow_rmw_if.sv
// Store request / data memory bundle for store_narrow_rmw.
// slave = the RMW block, master = the request source plus memory side.
interface store_narrow_rmw_if #(
    parameter int WORD_AW = 10
) ();
    logic               req_valid;
    logic               req_ready;
    logic [31:0]        req_addr;
    logic [31:0]        req_data;
    logic [1:0]         req_size;
    logic               done;
    logic               err_align;
    logic               trunc_ovf;
    logic [WORD_AW-1:0] mem_addr;
    logic               mem_rd_en;
    logic [31:0]        mem_rdata;
    logic               mem_wr_en;
    logic [31:0]        mem_wdata;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata,
        output req_ready, done, err_align, trunc_ovf,
               mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata,
        input  req_ready, done, err_align, trunc_ovf,
               mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/store_narrow_rmw_lane_merge.sv
// Combinational lane merge and truncation check for one store.
module store_lane_merge
    import store_narrow_rmw_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    output logic [31:0] merged_word,
    output logic        trunc_ovf
);
    assign merged_word = lane_merge(old_word, data, addr_lo, size);
    assign trunc_ovf   = trunc_check(data, size);
endmodule

// File: rtl/store_narrow_rmw.sv
// Narrowing store unit: word stores write directly, byte/half stores do a
// read-modify-write on a memory without byte enables.
module store_narrow_rmw
    import store_narrow_rmw_pkg::*;
#(
    parameter int WORD_AW = 10,
    parameter int RD_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    store_narrow_rmw_if.slave    bus
);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WORD_AW-1:0] addr_q;
    logic [1:0]         lo_q;
    logic [31:0]        data_q;
    logic [1:0]         size_q;
    logic               ovf_q;
    logic [31:0]        wr_word_q;

    logic               accept;
    logic               is_idle;
    logic               last_wait;
    logic [31:0]        lm_data;
    logic [1:0]         lm_lo;
    logic [1:0]         lm_size;
    logic [31:0]        lm_merged;
    logic               lm_ovf;

    assign is_idle   = (state_q == ST_IDLE);
    assign accept    = bus.req_valid && is_idle;
    assign last_wait = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);

    // In IDLE the merger sees the live request so the overflow flag is
    // evaluated at acceptance; afterwards it sees the latched request.
    assign lm_data = is_idle ? bus.req_data       : data_q;
    assign lm_lo   = is_idle ? bus.req_addr[1:0]  : lo_q;
    assign lm_size = is_idle ? bus.req_size       : size_q;

    store_lane_merge u_merge (
        .old_word    (bus.mem_rdata),
        .data        (lm_data),
        .addr_lo     (lm_lo),
        .size        (lm_size),
        .merged_word (lm_merged),
        .trunc_ovf   (lm_ovf)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Request latch, read-latency counter and write-word capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            lo_q      <= '0;
            data_q    <= '0;
            size_q    <= '0;
            ovf_q     <= 1'b0;
            wr_word_q <= '0;
        end else begin
            if (accept) begin
                addr_q    <= bus.req_addr[WORD_AW+1:2];
                lo_q      <= bus.req_addr[1:0];
                data_q    <= bus.req_data;
                size_q    <= bus.req_size;
                ovf_q     <= lm_ovf;
                wr_word_q <= bus.req_data;
            end
            if (state_q == ST_RD)   cnt_q <= '0;
            if (state_q == ST_WAIT) cnt_q <= cnt_q + 1'b1;
            if (last_wait)          wr_word_q <= lm_merged;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.mem_rd_en  = 1'b0;
        bus.mem_wr_en  = 1'b0;
        bus.done       = 1'b0;
        bus.err_align  = 1'b0;
        bus.trunc_ovf  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (size_illegal(bus.req_size, bus.req_addr[1:0])) state_d = ST_ERR;
                    else if (bus.req_size == SZ_WORD)                  state_d = ST_WR;
                    else                                               state_d = ST_RD;
                end
            end
            ST_RD: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = addr_q;
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                bus.mem_addr = addr_q;
                if (last_wait) state_d = ST_WR;
            end
            ST_WR: begin
                bus.mem_wr_en = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wr_word_q;
                bus.done      = 1'b1;
                bus.trunc_ovf = ovf_q;
                state_d       = ST_IDLE;
            end
            ST_ERR: begin
                bus.done      = 1'b1;
                bus.err_align = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Directed bench for store_narrow_rmw: an RD_LAT=1 instance and an
// RD_LAT=3 instance, each with its own word memory model.
module tb_store_narrow_rmw;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    store_narrow_rmw_if #(.WORD_AW(10)) b1 ();
    store_narrow_rmw_if #(.WORD_AW(10)) b3 ();

    store_narrow_rmw #(.WORD_AW(10), .RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    store_narrow_rmw #(.WORD_AW(10), .RD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic        pl_en1 = 1'b0;
    logic        pl_en3 = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] rd1 = '0;
    logic [31:0] p1 = '0, p2 = '0, p3 = '0;

    // Memory with one-cycle read latency.
    always @(posedge clk) begin
        if (pl_en1)             mem1[pl_addr] <= pl_data;
        else if (b1.mem_wr_en)  mem1[b1.mem_addr] <= b1.mem_wdata;
        if (b1.mem_rd_en)       rd1 <= mem1[b1.mem_addr];
    end
    assign b1.mem_rdata = rd1;

    // Memory with three-cycle read latency.
    always @(posedge clk) begin
        if (pl_en3)             mem3[pl_addr] <= pl_data;
        else if (b3.mem_wr_en)  mem3[b3.mem_addr] <= b3.mem_wdata;
        if (b3.mem_rd_en)       p1 <= mem3[b3.mem_addr];
        p2 <= p1;
        p3 <= p2;
    end
    assign b3.mem_rdata = p3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int sel, input logic [9:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        if (sel == 0) pl_en1 = 1'b1; else pl_en3 = 1'b1;
        tick();
        pl_en1 = 1'b0;
        pl_en3 = 1'b0;
    endtask

    // Present one request for one cycle, then scramble the inputs.
    task automatic do_req(input int sel, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        if (sel == 0) begin
            chk("ready_before_req1", 32'(b1.req_ready), 32'd1);
            b1.req_valid = 1'b1; b1.req_addr = a; b1.req_data = d; b1.req_size = sz;
        end else begin
            chk("ready_before_req3", 32'(b3.req_ready), 32'd1);
            b3.req_valid = 1'b1; b3.req_addr = a; b3.req_data = d; b3.req_size = sz;
        end
        tick();
        b1.req_valid = 1'b0; b1.req_addr = '0; b1.req_data = 32'hFFFF_FFFF;
        b3.req_valid = 1'b0; b3.req_addr = '0; b3.req_data = 32'hFFFF_FFFF;
    endtask

    // Observe one cycle of outputs at the falling edge, then advance.
    task automatic obs(input int sel, input string tag, input bit rdy, input bit rd, input bit wr,
                       input bit dn, input bit er, input bit ov, input logic [9:0] ma,
                       input logic [31:0] wd);
        logic        o_rdy, o_rd, o_wr, o_dn, o_er, o_ov;
        logic [9:0]  o_ma;
        logic [31:0] o_wd;
        @(negedge clk);
        if (sel == 0) begin
            o_rdy = b1.req_ready; o_rd = b1.mem_rd_en; o_wr = b1.mem_wr_en; o_dn = b1.done;
            o_er = b1.err_align; o_ov = b1.trunc_ovf; o_ma = b1.mem_addr; o_wd = b1.mem_wdata;
        end else begin
            o_rdy = b3.req_ready; o_rd = b3.mem_rd_en; o_wr = b3.mem_wr_en; o_dn = b3.done;
            o_er = b3.err_align; o_ov = b3.trunc_ovf; o_ma = b3.mem_addr; o_wd = b3.mem_wdata;
        end
        chk({tag, ".ready"}, 32'(o_rdy), 32'(rdy));
        chk({tag, ".rd_en"}, 32'(o_rd), 32'(rd));
        chk({tag, ".wr_en"}, 32'(o_wr), 32'(wr));
        chk({tag, ".done"}, 32'(o_dn), 32'(dn));
        chk({tag, ".err"}, 32'(o_er), 32'(er));
        chk({tag, ".ovf"}, 32'(o_ov), 32'(ov));
        chk({tag, ".addr"}, 32'(o_ma), 32'(ma));
        if (wr) chk({tag, ".wdata"}, o_wd, wd);
        tick();
    endtask

    initial begin
        b1.req_valid = 1'b0; b1.req_addr = '0; b1.req_data = '0; b1.req_size = 2'b00;
        b3.req_valid = 1'b0; b3.req_addr = '0; b3.req_data = '0; b3.req_size = 2'b00;
        tick();

        // Reset state, with a request presented that must be ignored.
        preload(0, 10'd3, 32'h1122_3344);
        preload(0, 10'd0, 32'hCAFE_F00D);
        preload(0, 10'd8, 32'h5555_5555);
        preload(0, 10'd5, 32'hA5A5_A5A5);
        preload(0, 10'd4, 32'h0000_0000);
        preload(3, 10'd2, 32'h9988_7766);
        b1.req_valid = 1'b1; b1.req_addr = 32'h10; b1.req_data = 32'h1234_5678; b1.req_size = 2'b10;
        tick();
        obs(0, "reset", 1, 0, 0, 0, 0, 0, 10'd0, 32'd0);
        @(negedge clk);
        chk("reset.wdata", b1.mem_wdata, 32'd0);
        chk("reset.mem4", mem1[4], 32'h0);
        b1.req_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Word store: write on the cycle after accept.
        do_req(0, 32'h0000_0010, 32'hDEAD_BEEF, 2'b10);
        obs(0, "word.wr", 0, 0, 1, 1, 0, 0, 10'd4, 32'hDEAD_BEEF);
        obs(0, "word.idle", 1, 0, 0, 0, 0, 0, 10'd0, 32'd0);
        chk("word.mem4", mem1[4], 32'hDEAD_BEEF);

        // Byte RMW into lane 2 of word 3.
        do_req(0, 32'h0000_000E, 32'h0000_00AA, 2'b00);
        obs(0, "byte.rd", 0, 1, 0, 0, 0, 0, 10'd3, 32'd0);
        obs(0, "byte.wait", 0, 0, 0, 0, 0, 0, 10'd3, 32'd0);
        obs(0, "byte.wr", 0, 0, 1, 1, 0, 0, 10'd3, 32'h11AA_3344);
        chk("byte.mem3", mem1[3], 32'h11AA_3344);

        // Byte with lost upper bits, lane 0 of word 3 (back-to-back).
        do_req(0, 32'h0000_000C, 32'h0000_0180, 2'b00);
        obs(0, "byteovf.rd", 0, 1, 0, 0, 0, 0, 10'd3, 32'd0);
        obs(0, "byteovf.wait", 0, 0, 0, 0, 0, 0, 10'd3, 32'd0);
        obs(0, "byteovf.wr", 0, 0, 1, 1, 0, 1, 10'd3, 32'h11AA_3380);

        // Half into the upper lane of word 0, first with overflow then sign-extended.
        do_req(0, 32'h0000_0002, 32'h0001_8000, 2'b01);
        obs(0, "half1.rd", 0, 1, 0, 0, 0, 0, 10'd0, 32'd0);
        obs(0, "half1.wait", 0, 0, 0, 0, 0, 0, 10'd0, 32'd0);
        obs(0, "half1.wr", 0, 0, 1, 1, 0, 1, 10'd0, 32'h8000_F00D);
        do_req(0, 32'h0000_0002, 32'hFFFF_8000, 2'b01);
        obs(0, "half2.rd", 0, 1, 0, 0, 0, 0, 10'd0, 32'd0);
        obs(0, "half2.wait", 0, 0, 0, 0, 0, 0, 10'd0, 32'd0);
        obs(0, "half2.wr", 0, 0, 1, 1, 0, 0, 10'd0, 32'h8000_F00D);

        // Alignment and illegal-size errors.
        do_req(0, 32'h0000_0003, 32'h0000_1234, 2'b01);
        obs(0, "err_half", 0, 0, 0, 1, 1, 0, 10'd0, 32'd0);
        do_req(0, 32'h0000_0002, 32'h0000_1234, 2'b10);
        obs(0, "err_word", 0, 0, 0, 1, 1, 0, 10'd0, 32'd0);
        do_req(0, 32'h0000_0020, 32'h1234_5678, 2'b11);
        obs(0, "err_size", 0, 0, 0, 1, 1, 0, 10'd0, 32'd0);
        obs(0, "err.idle", 1, 0, 0, 0, 0, 0, 10'd0, 32'd0);
        chk("err.mem0", mem1[0], 32'h8000_F00D);
        chk("err.mem8", mem1[8], 32'h5555_5555);

        // Reset during WAIT: no write, no done.
        do_req(0, 32'h0000_0014, 32'h0000_0077, 2'b00);
        obs(0, "rst.rd", 0, 1, 0, 0, 0, 0, 10'd5, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst.now.wr", 32'(b1.mem_wr_en), 32'd0);
        chk("rst.now.done", 32'(b1.done), 32'd0);
        chk("rst.now.addr", 32'(b1.mem_addr), 32'd0);
        chk("rst.now.ready", 32'(b1.req_ready), 32'd1);
        obs(0, "rst.hold1", 1, 0, 0, 0, 0, 0, 10'd0, 32'd0);
        obs(0, "rst.hold2", 1, 0, 0, 0, 0, 0, 10'd0, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst.mem5", mem1[5], 32'hA5A5_A5A5);
        do_req(0, 32'h0000_0014, 32'h0000_0077, 2'b00);
        obs(0, "rst2.rd", 0, 1, 0, 0, 0, 0, 10'd5, 32'd0);
        obs(0, "rst2.wait", 0, 0, 0, 0, 0, 0, 10'd5, 32'd0);
        obs(0, "rst2.wr", 0, 0, 1, 1, 0, 0, 10'd5, 32'hA5A5_A577);
        chk("rst2.mem5", mem1[5], 32'hA5A5_A577);

        // RD_LAT=3: back-to-back bytes to lanes 0 and 1 of word 2.
        do_req(3, 32'h0000_0008, 32'h0000_0011, 2'b00);
        obs(3, "l3a.rd", 0, 1, 0, 0, 0, 0, 10'd2, 32'd0);
        obs(3, "l3a.w1", 0, 0, 0, 0, 0, 0, 10'd2, 32'd0);
        obs(3, "l3a.w2", 0, 0, 0, 0, 0, 0, 10'd2, 32'd0);
        obs(3, "l3a.w3", 0, 0, 0, 0, 0, 0, 10'd2, 32'd0);
        obs(3, "l3a.wr", 0, 0, 1, 1, 0, 0, 10'd2, 32'h9988_7711);
        do_req(3, 32'h0000_0009, 32'h0000_0022, 2'b00);
        obs(3, "l3b.rd", 0, 1, 0, 0, 0, 0, 10'd2, 32'd0);
        obs(3, "l3b.w1", 0, 0, 0, 0, 0, 0, 10'd2, 32'd0);
        obs(3, "l3b.w2", 0, 0, 0, 0, 0, 0, 10'd2, 32'd0);
        obs(3, "l3b.w3", 0, 0, 0, 0, 0, 0, 10'd2, 32'd0);
        obs(3, "l3b.wr", 0, 0, 1, 1, 0, 0, 10'd2, 32'h9988_2211);
        obs(3, "l3.idle", 1, 0, 0, 0, 0, 0, 10'd0, 32'd0);
        chk("l3.mem2", mem3[2], 32'h9988_2211);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
